ct_l2cache_tag_array_cfg: RTL and testbench
===========================================

// Module: ct_l2cache_tag_array_cfg
// PURPOSE
//  Configurable L2C tag array: WAYS ways of TAG_W-bit tags over 2**IDX_W sets, split into WAYS/WAYS_PER_BANK SRAM banks.
//  Successor to the fixed 16-way tag array. Adds per-way even parity, a post-reset zero-fill sweep, a valid/ready request port,
//  bank clock gating on partial writes, and an optional output register. Sits between the L2C tag pipeline and the tag SRAM macros.
// PARAMETERS
//  WAYS           16  number of ways; must be a multiple of WAYS_PER_BANK
//  WAYS_PER_BANK  4   ways per SRAM bank; bank width = WAYS_PER_BANK*(TAG_W+1)
//  TAG_W          26  tag payload bits per way, excluding parity
//  IDX_W          9   set index width; DEPTH = 2**IDX_W
//  OUT_REG        1   1: register rsp outputs (+1 cycle latency)
//  INIT_EN        1   1: zero-fill all sets after reset
// PORTS
//  tag_clk      in   1             clock
//  tag_rst      in   1             asynchronous reset, active-high
//  req_vld      in   1             request valid
//  req_rdy      out  1             array accepts a request this cycle
//  req_wr       in   1             1 = write, 0 = read
//  req_idx      in   IDX_W         set index
//  req_way_wen  in   WAYS          per-way write enable, active-high; ignored on reads
//  req_din      in   WAYS*TAG_W    write data; way w occupies [w*TAG_W +: TAG_W]
//  init_start   in   1             pulse: re-run the zero-fill sweep
//  init_busy    out  1             sweep in progress
//  rsp_vld      out  1             read data valid; there is no backpressure
//  rsp_dout     out  WAYS*TAG_W    read tags, laid out as req_din
//  rsp_perr     out  WAYS          per-way parity error on the read
// BEHAVIOUR
//  - Reset: all outputs 0, except init_busy=INIT_EN and req_rdy=!INIT_EN. The FSM enters INIT if INIT_EN, otherwise IDLE.
//  - FSM IDLE/INIT:
//      INIT: counter walks 0..DEPTH-1, writing all-zero (payload+parity) to every way at one set per cycle.
//      INIT->IDLE after the DEPTH-1 write; the sweep takes DEPTH cycles.
//      IDLE->INIT on init_start, but only once the read pipeline is empty. init_start during INIT is ignored.
//      Reset asserted mid-sweep restarts the sweep at set 0.
//  - req_rdy = (state==IDLE) && !(init_start pending). A request is accepted when req_vld&&req_rdy.
//  - Write: stored parity per way = ^req_din way slice. Bank b is enabled only if any of its ways has req_way_wen set.
//    All-zero req_way_wen is a no-op: no bank is enabled.
//  - Read: all banks enabled. SRAM latency is 1 cycle.
//      rsp_vld asserts at accept+1 (OUT_REG=0) or accept+2 (OUT_REG=1).
//      Fully pipelined: one read accepted per cycle.
//  - rsp_perr[w] = ^{stored parity, stored payload} of way w, qualified by rsp_vld; it is 0 when rsp_vld=0.
//    rsp_dout holds its last value when rsp_vld=0.
//  - Read of a set in the cycle after a write to it returns the new data; no bypass is needed, since SRAM ordering covers it.
//  - Reads in flight when reset asserts are dropped; no rsp_vld is produced for them.
//  - Sweep writes and requests never share a cycle: req_rdy=0 during INIT.
// STRUCTURE
//  - Shared package ct_l2c_tag_pkg (or the cpu_cfig.h defines) holds:
//      default TAG_W/IDX_W per L2 size;
//      function for the parity of a way slice;
//      FSM state encoding.
//  - Sub-module ct_l2cache_tag_bank: one bank with params DEPTH and WIDTH, wrapping the technology spsram macro.
//      Ports: CLK, CEN/GWEN/WEN active-low, A, D, Q.
//      Generate NBANK = WAYS/WAYS_PER_BANK instances.
//  - Top level holds the FSM, sweep counter, per-way parity gen/check, read-valid pipeline, and optional output flops.
// TESTING
//  1. Reset, INIT_EN=1, IDX_W=4 -> init_busy=1 for 16 cycles, req_rdy=0, then req_rdy=1. A read of every set gives dout=0, perr=0.
//  2. Write idx=5, way_wen=16'h0003, din way0=26'h0ABCDEF, way1=26'h3FFFFFF. Read idx 5 ->
//     way0/way1 hold those values, other ways 0, rsp_vld at +2 with OUT_REG=1 and at +1 with OUT_REG=0.
//  3. Write way_wen=16'h0010 -> only bank1 CEN low. way_wen=0 -> no bank enabled. Contents unchanged.
//  4. Backdoor-flip one payload bit of way 7 at idx 3, then read idx 3 -> rsp_perr=16'h0080, dout shows the flipped value.
//  5. Reads to idx 0,1,2 on consecutive cycles, then init_start -> three rsp_vld pulses in order.
//     The sweep starts after the pipe drains; init_start during the sweep is ignored.
//  6. Assert tag_rst at sweep set 7 -> after release the sweep restarts at set 0 and takes DEPTH cycles. No stray rsp_vld.

Source files
------------

// File: rtl/ct_l2cache_tag_array_cfg_pkg.sv
// Shared types and helpers for the configurable L2C tag array.
// Holds per-L2-size default geometry, the FSM state encoding and the way parity function.
// No logic of its own; imported by the array top.
package ct_l2cache_tag_array_cfg_pkg;

  // Default tag/index geometry per L2 size (16 ways, 64B lines)
  localparam int L2_512K_TAG_W = 26;
  localparam int L2_512K_IDX_W = 9;
  localparam int L2_1M_TAG_W   = 25;
  localparam int L2_1M_IDX_W   = 10;
  localparam int DFLT_TAG_W    = L2_512K_TAG_W;
  localparam int DFLT_IDX_W    = L2_512K_IDX_W;

  // IDLE serves requests; INIT owns the SRAM for the zero-fill sweep
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_INIT = 1'b1
  } tag_state_e;

  // Even parity of a way slice; callers zero-extend narrower slices,
  // which leaves the XOR reduction unchanged.
  function automatic logic way_parity(input logic [63:0] slice);
    return ^slice;
  endfunction

endpackage

// File: rtl/ct_l2cache_tag_array_cfg_if.sv
// Request/response bundle between the L2C tag pipeline and the tag array.
// master = tag pipeline side, slave = tag array side.
// Requests use valid/ready; responses have no backpressure.
interface ct_l2cache_tag_array_cfg_if #(
  parameter int WAYS  = 16,
  parameter int TAG_W = 26,
  parameter int IDX_W = 9
) ();
  logic                    req_vld;
  logic                    req_rdy;
  logic                    req_wr;
  logic [IDX_W-1:0]        req_idx;
  logic [WAYS-1:0]         req_way_wen;
  logic [WAYS*TAG_W-1:0]   req_din;
  logic                    init_start;
  logic                    init_busy;
  logic                    rsp_vld;
  logic [WAYS*TAG_W-1:0]   rsp_dout;
  logic [WAYS-1:0]         rsp_perr;

  modport master (
    output req_vld, req_wr, req_idx, req_way_wen, req_din, init_start,
    input  req_rdy, init_busy, rsp_vld, rsp_dout, rsp_perr
  );

  modport slave (
    input  req_vld, req_wr, req_idx, req_way_wen, req_din, init_start,
    output req_rdy, init_busy, rsp_vld, rsp_dout, rsp_perr
  );
endinterface

// File: rtl/ct_l2cache_tag_bank.sv
// Single-port SRAM bank model standing in for the technology spsram macro.
// Latency: Q updates 1 cycle after a read (CEN=0, GWEN=1); Q holds otherwise.
// No backpressure; CEN/GWEN/WEN are active-low, WEN is a per-bit write mask.
module ct_l2cache_tag_bank #(
  parameter int DEPTH = 512,
  parameter int WIDTH = 108,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             CEN,
  input  logic             GWEN,
  input  logic [WIDTH-1:0] WEN,
  input  logic [AW-1:0]    A,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Masked write or registered read; the array has no reset, like the macro
  always_ff @(posedge CLK) begin
    if (!CEN) begin
      if (!GWEN) begin
        mem[A] <= (mem[A] & WEN) | (D & ~WEN);
      end else begin
        Q <= mem[A];
      end
    end
  end

endmodule

// File: rtl/ct_l2cache_tag_array_cfg.sv
// Configurable L2C tag array: parity per way, zero-fill sweep, bank gating on partial writes.
// Latency: rsp_vld at accept+1 (OUT_REG=0) or accept+2 (OUT_REG=1); one read per cycle.
// Backpressure: req_rdy low during the sweep and while an init_start waits for reads to drain.
module ct_l2cache_tag_array_cfg
  import ct_l2cache_tag_array_cfg_pkg::*;
#(
  parameter int WAYS          = 16,
  parameter int WAYS_PER_BANK = 4,
  parameter int TAG_W         = DFLT_TAG_W,
  parameter int IDX_W         = DFLT_IDX_W,
  parameter int OUT_REG       = 1,
  parameter int INIT_EN       = 1
) (
  input  logic                        tag_clk,
  input  logic                        tag_rst,
  ct_l2cache_tag_array_cfg_if.slave   bus
);

  localparam int NBANK  = WAYS / WAYS_PER_BANK;
  localparam int DEPTH  = 2 ** IDX_W;
  localparam int WAY_W  = TAG_W + 1;               // {parity, payload}
  localparam int BANK_W = WAYS_PER_BANK * WAY_W;

  tag_state_e              state_q, state_d;
  logic [IDX_W-1:0]        sweep_cnt_q, sweep_cnt_d;
  logic                    init_pend_q, init_pend_d;
  logic                    rd_p1_q;                 // SRAM Q valid this cycle
  logic                    vld_q;                   // output-register stage valid
  logic [WAYS*TAG_W-1:0]   dout_q;
  logic [WAYS-1:0]         perr_q;

  logic                    init_req;
  logic                    pipe_empty;
  logic                    rdy;
  logic                    acc_rd;
  logic                    acc_wr;

  logic [NBANK-1:0]        bank_cen_n;
  logic                    bank_gwen_n;
  logic [NBANK*BANK_W-1:0] bank_wen_n;
  logic [NBANK*BANK_W-1:0] bank_d;
  logic [NBANK*BANK_W-1:0] bank_q;
  logic [IDX_W-1:0]        bank_a;

  logic [WAYS*TAG_W-1:0]   dout_raw;
  logic [WAYS-1:0]         perr_raw;

  // An init_start seen in IDLE stays pending until the read pipe drains
  assign init_req   = init_pend_q || ((state_q == ST_IDLE) && bus.init_start);
  assign pipe_empty = !rd_p1_q && !vld_q;
  assign rdy        = (state_q == ST_IDLE) && !init_req;
  assign acc_rd     = bus.req_vld && rdy && !bus.req_wr;
  assign acc_wr     = bus.req_vld && rdy && bus.req_wr;

  assign bus.req_rdy   = rdy;
  assign bus.init_busy = (state_q == ST_INIT);

  // Next state: enter the sweep once drained, leave it after the last set
  always_comb begin
    state_d     = state_q;
    sweep_cnt_d = sweep_cnt_q;
    init_pend_d = init_pend_q;
    case (state_q)
      ST_IDLE: begin
        init_pend_d = init_req;
        if (init_req && pipe_empty) begin
          state_d     = ST_INIT;
          init_pend_d = 1'b0;
          sweep_cnt_d = '0;
        end
      end
      ST_INIT: begin
        init_pend_d = 1'b0;
        sweep_cnt_d = sweep_cnt_q + IDX_W'(1);
        if (&sweep_cnt_q) begin
          state_d     = ST_IDLE;
          sweep_cnt_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state, sweep counter and pending init request
  always_ff @(posedge tag_clk or posedge tag_rst) begin
    if (tag_rst) begin
      state_q     <= (INIT_EN != 0) ? ST_INIT : ST_IDLE;
      sweep_cnt_q <= '0;
      init_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sweep_cnt_q <= sweep_cnt_d;
      init_pend_q <= init_pend_d;
    end
  end

  // SRAM controls: sweep writes zeros everywhere, reads enable all banks,
  // writes enable only banks that own at least one selected way
  always_comb begin
    bank_cen_n  = '1;
    bank_gwen_n = 1'b1;
    bank_wen_n  = '1;
    bank_d      = '0;
    bank_a      = bus.req_idx;
    if (state_q == ST_INIT) begin
      bank_cen_n  = '0;
      bank_gwen_n = 1'b0;
      bank_wen_n  = '0;
      bank_a      = sweep_cnt_q;
    end else if (acc_rd) begin
      bank_cen_n = '0;
    end else if (acc_wr) begin
      bank_gwen_n = 1'b0;
      for (int w = 0; w < WAYS; w++) begin
        bank_d[w*WAY_W +: WAY_W] = {way_parity(64'(bus.req_din[w*TAG_W +: TAG_W])),
                                    bus.req_din[w*TAG_W +: TAG_W]};
        bank_wen_n[w*WAY_W +: WAY_W] = {WAY_W{!bus.req_way_wen[w]}};
      end
      for (int b = 0; b < NBANK; b++) begin
        bank_cen_n[b] = ~|bus.req_way_wen[b*WAYS_PER_BANK +: WAYS_PER_BANK];
      end
    end
  end

  for (genvar b = 0; b < NBANK; b++) begin : g_bank
    ct_l2cache_tag_bank #(
      .DEPTH (DEPTH),
      .WIDTH (BANK_W)
    ) u_bank (
      .CLK  (tag_clk),
      .CEN  (bank_cen_n[b]),
      .GWEN (bank_gwen_n),
      .WEN  (bank_wen_n[b*BANK_W +: BANK_W]),
      .A    (bank_a),
      .D    (bank_d[b*BANK_W +: BANK_W]),
      .Q    (bank_q[b*BANK_W +: BANK_W])
    );
  end

  // Strip parity from SRAM data and check each way over {parity, payload}
  always_comb begin
    dout_raw = '0;
    perr_raw = '0;
    for (int w = 0; w < WAYS; w++) begin
      dout_raw[w*TAG_W +: TAG_W] = bank_q[w*WAY_W +: TAG_W];
      perr_raw[w]                = way_parity(64'(bank_q[w*WAY_W +: WAY_W]));
    end
  end

  // Read-valid pipeline; reset drops reads in flight. dout_q doubles as the
  // hold value so rsp_dout is stable between responses in both modes.
  always_ff @(posedge tag_clk or posedge tag_rst) begin
    if (tag_rst) begin
      rd_p1_q <= 1'b0;
      vld_q   <= 1'b0;
      dout_q  <= '0;
      perr_q  <= '0;
    end else begin
      rd_p1_q <= acc_rd;
      vld_q   <= rd_p1_q;
      perr_q  <= rd_p1_q ? perr_raw : '0;
      if (rd_p1_q) begin
        dout_q <= dout_raw;
      end
    end
  end

  if (OUT_REG != 0) begin : g_oreg
    assign bus.rsp_vld  = vld_q;
    assign bus.rsp_dout = dout_q;
    assign bus.rsp_perr = perr_q;
  end else begin : g_no_oreg
    assign bus.rsp_vld  = rd_p1_q;
    assign bus.rsp_dout = rd_p1_q ? dout_raw : dout_q;
    assign bus.rsp_perr = rd_p1_q ? perr_raw : '0;
  end

endmodule

// File: tb/tb_ct_l2cache_tag_array_cfg.sv
// Directed bench for the configurable L2C tag array (IDX_W=4, 16 ways, 4 banks).
// dut has OUT_REG=1; dut0 mirrors the same stimulus with OUT_REG=0 for the +1 latency checks.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_ct_l2cache_tag_array_cfg;
  localparam int WAYS  = 16;
  localparam int TAG_W = 26;
  localparam int IDX_W = 4;
  localparam int DW    = WAYS * TAG_W;

  logic tag_clk = 1'b0;
  logic tag_rst;
  int   checks = 0;
  int   errors = 0;

  always #5 tag_clk = ~tag_clk;

  ct_l2cache_tag_array_cfg_if #(.WAYS(WAYS), .TAG_W(TAG_W), .IDX_W(IDX_W)) m ();
  ct_l2cache_tag_array_cfg_if #(.WAYS(WAYS), .TAG_W(TAG_W), .IDX_W(IDX_W)) m0 ();

  assign m0.req_vld     = m.req_vld;
  assign m0.req_wr      = m.req_wr;
  assign m0.req_idx     = m.req_idx;
  assign m0.req_way_wen = m.req_way_wen;
  assign m0.req_din     = m.req_din;
  assign m0.init_start  = m.init_start;

  ct_l2cache_tag_array_cfg #(
    .WAYS(WAYS), .WAYS_PER_BANK(4), .TAG_W(TAG_W), .IDX_W(IDX_W), .OUT_REG(1), .INIT_EN(1)
  ) dut (
    .tag_clk (tag_clk),
    .tag_rst (tag_rst),
    .bus     (m)
  );

  ct_l2cache_tag_array_cfg #(
    .WAYS(WAYS), .WAYS_PER_BANK(4), .TAG_W(TAG_W), .IDX_W(IDX_W), .OUT_REG(0), .INIT_EN(1)
  ) dut0 (
    .tag_clk (tag_clk),
    .tag_rst (tag_rst),
    .bus     (m0)
  );

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive a write and leave it on the bus; the next task's edge replaces it
  task automatic wr(input logic [IDX_W-1:0] idx, input logic [WAYS-1:0] wen,
                    input logic [DW-1:0] din, output logic [3:0] cen);
    @(negedge tag_clk);
    m.req_vld = 1'b1; m.req_wr = 1'b1; m.req_idx = idx; m.req_way_wen = wen; m.req_din = din;
    #1 cen = dut.bank_cen_n;
  endtask

  task automatic idle();
    @(negedge tag_clk);
    m.req_vld = 1'b0; m.req_wr = 1'b0;
  endtask

  // Single read: dut0 answers at +1, dut at +2
  task automatic rd(input logic [IDX_W-1:0] idx, input string tag, input logic [DW-1:0] exp_d,
                    input logic [WAYS-1:0] exp_p, input logic [DW-1:0] exp_d0);
    @(negedge tag_clk);
    m.req_vld = 1'b1; m.req_wr = 1'b0; m.req_idx = idx; m.req_way_wen = '0;
    @(negedge tag_clk);
    m.req_vld = 1'b0;
    chk({tag, ".vld_oreg0_p1"}, m0.rsp_vld, 1);
    chk({tag, ".dout_oreg0"}, m0.rsp_dout, exp_d0);
    chk({tag, ".vld_p1"}, m.rsp_vld, 0);
    @(negedge tag_clk);
    chk({tag, ".vld_p2"}, m.rsp_vld, 1);
    chk({tag, ".dout"}, m.rsp_dout, exp_d);
    chk({tag, ".perr"}, m.rsp_perr, exp_p);
  endtask

  initial begin
    logic [DW-1:0] din, exp_d;
    logic [3:0]    cen;
    int            n;
    logic          seen;

    tag_rst = 1'b1;
    m.req_vld = 1'b0; m.req_wr = 1'b0; m.req_idx = '0; m.req_way_wen = '0;
    m.req_din = '0; m.init_start = 1'b0;

    // 1. Reset values, sweep length, all sets read back zero
    repeat (2) @(negedge tag_clk);
    chk("t1.rst_busy", m.init_busy, 1);
    chk("t1.rst_rdy", m.req_rdy, 0);
    chk("t1.rst_vld", m.rsp_vld, 0);
    chk("t1.rst_dout", m.rsp_dout, 0);
    chk("t1.rst_perr", m.rsp_perr, 0);
    tag_rst = 1'b0;
    n = 1; seen = 1'b0;
    repeat (30) begin
      @(negedge tag_clk);
      if (m.init_busy) begin n++; seen = seen | m.req_rdy; end
    end
    chk("t1.sweep_len", n, 16);
    chk("t1.rdy_in_sweep", seen, 0);
    chk("t1.rdy_after", m.req_rdy, 1);
    for (int i = 0; i < 16; i++) rd(IDX_W'(i), $sformatf("t1.set%0d", i), '0, '0, '0);

    // 2. Partial write to bank 0, read back in the very next cycle
    for (int w = 0; w < WAYS; w++) din[w*TAG_W +: TAG_W] = 26'h1555555;
    din[0 +: TAG_W]  = 26'h0ABCDEF;
    din[26 +: TAG_W] = 26'h3FFFFFF;
    exp_d = '0;
    exp_d[0 +: TAG_W]  = 26'h0ABCDEF;
    exp_d[26 +: TAG_W] = 26'h3FFFFFF;
    wr(4'd5, 16'h0003, din, cen);
    chk("t2.cen", cen, 4'b1110);
    rd(4'd5, "t2.rd5", exp_d, '0, exp_d);

    // 3. Single-way write gates only bank 1; empty mask gates all banks
    for (int w = 0; w < WAYS; w++) din[w*TAG_W +: TAG_W] = 26'h2AAAAAA;
    wr(4'd5, 16'h0010, din, cen);
    chk("t3.cen_way4", cen, 4'b1101);
    for (int w = 0; w < WAYS; w++) din[w*TAG_W +: TAG_W] = 26'h3FFFFFF;
    wr(4'd5, 16'h0000, din, cen);
    chk("t3.cen_none", cen, 4'b1111);
    exp_d[4*TAG_W +: TAG_W] = 26'h2AAAAAA;
    rd(4'd5, "t3.rd5", exp_d, '0, exp_d);

    // 4. Corrupt payload bit 0 of way 7 at set 3 (bank 1, local way 3)
    @(negedge tag_clk);
    dut.g_bank[1].u_bank.mem[3][81] = ~dut.g_bank[1].u_bank.mem[3][81];
    exp_d = '0;
    exp_d[7*TAG_W] = 1'b1;
    rd(4'd3, "t4.rd3", exp_d, 16'h0080, '0);
    @(negedge tag_clk);
    chk("t4.vld_after", m.rsp_vld, 0);
    chk("t4.perr_qual", m.rsp_perr, 0);
    chk("t4.dout_hold", m.rsp_dout, exp_d);

    // 5. Back-to-back reads, then init_start waits for the pipe to drain
    for (int s = 0; s < 3; s++) begin
      din = '0;
      din[0 +: TAG_W] = TAG_W'(s + 1);
      wr(IDX_W'(s), 16'h0001, din, cen);
    end
    idle();
    @(negedge tag_clk);
    m.req_vld = 1'b1; m.req_wr = 1'b0; m.req_idx = 4'd0;
    @(negedge tag_clk);
    m.req_idx = 4'd1;
    @(negedge tag_clk);
    chk("t5.vld0", m.rsp_vld, 1);
    chk("t5.dout0", m.rsp_dout[0 +: TAG_W], 1);
    m.req_idx = 4'd2;
    @(negedge tag_clk);
    chk("t5.vld1", m.rsp_vld, 1);
    chk("t5.dout1", m.rsp_dout[0 +: TAG_W], 2);
    m.req_vld = 1'b0; m.init_start = 1'b1;
    @(negedge tag_clk);
    chk("t5.vld2", m.rsp_vld, 1);
    chk("t5.dout2", m.rsp_dout[0 +: TAG_W], 3);
    chk("t5.rdy_pend", m.req_rdy, 0);
    chk("t5.busy_drain", m.init_busy, 0);
    m.init_start = 1'b0;
    @(negedge tag_clk);
    chk("t5.vld_end", m.rsp_vld, 0);
    chk("t5.busy_wait", m.init_busy, 0);
    @(negedge tag_clk);
    chk("t5.busy_start", m.init_busy, 1);
    chk("t5.rdy_sweep", m.req_rdy, 0);
    n = 1;
    m.init_start = 1'b1;
    repeat (40) begin
      @(negedge tag_clk);
      m.init_start = 1'b0;
      if (m.init_busy) n++;
    end
    chk("t5.sweep_len", n, 16);
    chk("t5.rdy_after", m.req_rdy, 1);
    rd(4'd1, "t5.zeroed", '0, '0, '0);

    // 6. Reset mid-sweep restarts at set 0; reads in flight are dropped
    @(negedge tag_clk);
    m.init_start = 1'b1;
    @(negedge tag_clk);
    m.init_start = 1'b0;
    n = 0;
    while (n < 40 && dut.sweep_cnt_q != 4'd7) begin
      @(negedge tag_clk);
      n++;
    end
    chk("t6.reach7", dut.sweep_cnt_q, 7);
    tag_rst = 1'b1;
    #1;
    chk("t6.cnt_rst", dut.sweep_cnt_q, 0);
    chk("t6.busy_rst", m.init_busy, 1);
    @(negedge tag_clk);
    tag_rst = 1'b0;
    n = 1; seen = 1'b0;
    repeat (30) begin
      @(negedge tag_clk);
      if (m.init_busy) n++;
      seen = seen | m.rsp_vld | m0.rsp_vld;
    end
    chk("t6.sweep_len", n, 16);
    chk("t6.no_stray", seen, 0);

    @(negedge tag_clk);
    m.req_vld = 1'b1; m.req_wr = 1'b0; m.req_idx = 4'd2;
    @(negedge tag_clk);
    m.req_vld = 1'b0;
    tag_rst = 1'b1;
    #1;
    chk("t6.drop_vld_now", m.rsp_vld, 0);
    @(negedge tag_clk);
    tag_rst = 1'b0;
    n = 1; seen = 1'b0;
    repeat (30) begin
      @(negedge tag_clk);
      if (m.init_busy) n++;
      seen = seen | m.rsp_vld | m0.rsp_vld;
    end
    chk("t6.drop_sweep_len", n, 16);
    chk("t6.drop_no_vld", seen, 0);
    chk("t6.rdy_end", m.req_rdy, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
